// File: rtl/sample_in_ball_index_gen_if.sv
// Handshake bundle between the SHAKE256 squeeze stream, the SampleInBall
// index generator and the shuffler. The generator is the slave of the stream
// side and drives the shuffle request side.
interface sample_in_ball_index_gen_if #(
  parameter int SIB_SAMPLE_W = 8
) ();
  logic                    data_valid_i;
  logic                    data_hold_o;
  logic [63:0]             data_i;
  logic                    valid_o;
  logic                    hold_i;
  logic [SIB_SAMPLE_W-1:0] indexi_o;
  logic [SIB_SAMPLE_W-1:0] indexj_o;
  logic                    sign_o;

  modport slave (
    input  data_valid_i, data_i, hold_i,
    output data_hold_o, valid_o, indexi_o, indexj_o, sign_o
  );

  modport master (
    output data_valid_i, data_i, hold_i,
    input  data_hold_o, valid_o, indexi_o, indexj_o, sign_o
  );
endinterface

// File: rtl/sample_in_ball_index_gen.sv
// SampleInBall index generator: captures the sign word from the c~ squeeze
// stream, then rejection-samples bytes j <= i and hands {i, j, sign} to the
// shuffler for i = 256-TAU .. 255.
//
// state  | meaning
// IDLE   | waiting for start_i, stream held off
// SIGN   | accepting the first stream word as sign bits
// SAMPLE | byte buffer refill / reject / shuffle request issue
// DONE   | one-cycle done_o pulse, then back to IDLE
module sample_in_ball_index_gen #(
  parameter int TAU          = 60,
  parameter int SIB_SAMPLE_W = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic zeroize,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  sample_in_ball_index_gen_if.slave sib
);

  // i runs 9 bits wide so the end compare at 255 never wraps
  localparam logic [8:0] I_FIRST = 9'(256 - TAU);
  localparam logic [8:0] I_LAST  = 9'd255;

  typedef enum logic [1:0] {IDLE, SIGN, SAMPLE, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_i;
  logic [63:0] r_sign;
  logic [63:0] r_buf;
  logic [2:0]  r_ptr;
  logic        r_buf_full;

  logic [7:0]  w_cur;
  logic [5:0]  w_off;
  logic        w_hold;
  logic        w_accept;
  logic        w_reject;
  logic        w_xfer;
  logic        w_word_xfer;
  logic        w_last;

  assign w_cur       = r_buf[{r_ptr, 3'b000} +: 8];
  assign w_off       = 6'(r_i - I_FIRST);
  assign w_xfer      = w_accept & ~sib.hold_i;
  assign w_word_xfer = sib.data_valid_i & ~w_hold;
  assign w_last      = (r_i == I_LAST);

  assign sib.data_hold_o = w_hold;
  assign sib.valid_o     = w_accept;
  assign sib.indexi_o    = w_accept ? SIB_SAMPLE_W'(r_i[7:0]) : '0;
  assign sib.indexj_o    = w_accept ? SIB_SAMPLE_W'(w_cur) : '0;
  assign sib.sign_o      = w_accept & r_sign[w_off];

  // State register; zeroize forces IDLE on the next edge regardless of handshake
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       r_state <= IDLE;
    else if (zeroize) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next state, stream backpressure and accept/reject decode of the current byte
  always_comb begin
    w_state_nxt = r_state;
    w_hold      = 1'b1;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = SIGN;
      end
      SIGN: begin
        busy_o = 1'b1;
        w_hold = 1'b0;
        if (sib.data_valid_i) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy_o = 1'b1;
        w_hold = r_buf_full;
        if (r_buf_full) begin
          if ({1'b0, w_cur} <= r_i) w_accept = 1'b1;
          else                      w_reject = 1'b1;
        end
        if (w_accept && !sib.hold_i && (r_i == I_LAST)) w_state_nxt = DONE;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: index counter, sign word, byte buffer with read pointer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_i        <= '0;
      r_sign     <= '0;
      r_buf      <= '0;
      r_ptr      <= '0;
      r_buf_full <= 1'b0;
    end else if (zeroize) begin
      r_i        <= '0;
      r_sign     <= '0;
      r_buf      <= '0;
      r_ptr      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) r_i <= I_FIRST;
        end
        SIGN: begin
          if (w_word_xfer) begin
            r_sign     <= sib.data_i;
            r_ptr      <= '0;
            r_buf_full <= 1'b0;
          end
        end
        SAMPLE: begin
          if (w_word_xfer) begin
            r_buf      <= sib.data_i;
            r_ptr      <= '0;
            r_buf_full <= 1'b1;
          end else if (w_xfer && w_last) begin
            // leftover bytes of the last word are dropped
            r_buf      <= '0;
            r_ptr      <= '0;
            r_buf_full <= 1'b0;
            r_i        <= '0;
          end else if (w_xfer || w_reject) begin
            r_ptr <= r_ptr + 3'd1;
            if (r_ptr == 3'd7) r_buf_full <= 1'b0;
            if (w_xfer) r_i <= r_i + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_in_ball_index_gen.sv
// Bench for sample_in_ball_index_gen: a transaction-level SampleInBall model
// builds the byte stream and the expected {i, j, sign} sequence; a
// cycle loop drives the stream and a shuffler and compares every request.
module tb_sample_in_ball_index_gen;
  localparam int TAU   = 60;
  localparam int FIRST = 256 - TAU;

  typedef struct {
    logic [7:0] i;
    logic [7:0] j;
    logic       s;
  } xfer_t;

  logic clk     = 1'b0;
  logic rst_b   = 1'b0;
  logic zeroize = 1'b0;
  logic start_i = 1'b0;
  logic busy_o;
  logic done_o;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0] pre[$];

  sample_in_ball_index_gen_if #(.SIB_SAMPLE_W(8)) sib ();

  sample_in_ball_index_gen #(.TAU(TAU), .SIB_SAMPLE_W(8)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .zeroize (zeroize),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sib     (sib)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // hmode: 0 no hold, 1 hold each new request one cycle, 2 random hold
  task automatic run_case(input string name, input logic [63:0] sgn, input int hmode,
                          input bit rgap, input int lat, input int gap_word,
                          input int zero_at, input bit poke_start);
    xfer_t       exq[$];
    xfer_t       e;
    logic [7:0]  bq[$];
    logic [63:0] words[$];
    logic [63:0] w;
    logic [7:0]  b;
    int pidx = 0;
    int widx = 0;
    int cyc = 0;
    int w1_cyc = -1;
    int fv_cyc = -1;
    int gap_left = 5;
    bit held = 1'b0;
    bit resume = 1'b0;
    bit hold = 1'b0;
    bit done_seen = 1'b0;
    bit offer;

    // reference: rejection sampling straight from the algorithm
    for (int i = FIRST; i < 256; i++) begin
      do begin
        b = (pidx < pre.size()) ? pre[pidx] : 8'($urandom);
        pidx++;
        bq.push_back(b);
      end while (int'(b) > i);
      e.i = 8'(i);
      e.j = b;
      e.s = sgn[i-FIRST];
      exq.push_back(e);
    end
    while (bq.size() % 8 != 0) bq.push_back(8'($urandom));
    words.push_back(sgn);
    for (int k = 0; k < bq.size(); k += 8) begin
      w = '0;
      for (int m = 0; m < 8; m++) w[8*m +: 8] = bq[k+m];
      words.push_back(w);
    end

    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk({name, "_busy_start"}, 64'(busy_o), 64'd1);

    while (!done_seen && cyc < 3000) begin
      hold             = 1'b0;
      start_i          = 1'b0;
      sib.hold_i       = 1'b0;
      sib.data_valid_i = 1'b0;
      sib.data_i       = {$urandom, $urandom};
      if (poke_start && cyc == 20) start_i = 1'b1;
      if (resume) begin
        chk({name, "_resume_valid"}, 64'(sib.valid_o), 64'd1);
        resume = 1'b0;
      end
      if (sib.valid_o) begin
        if (fv_cyc < 0) fv_cyc = cyc;
        if (exq.size() == 0) begin
          chk({name, "_extra_valid"}, 64'(sib.valid_o), 64'd0);
        end else begin
          chk({name, "_indexi"}, 64'(sib.indexi_o), 64'(exq[0].i));
          chk({name, "_indexj"}, 64'(sib.indexj_o), 64'(exq[0].j));
          chk({name, "_sign"}, 64'(sib.sign_o), 64'(exq[0].s));
          chk({name, "_busy"}, 64'(busy_o), 64'd1);
          if (zero_at != 0 && exq[0].i == 8'(zero_at)) begin
            sib.hold_i = 1'b1;
            zeroize    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            zeroize    = 1'b0;
            sib.hold_i = 1'b0;
            chk({name, "_zero_valid"}, 64'(sib.valid_o), 64'd0);
            chk({name, "_zero_busy"}, 64'(busy_o), 64'd0);
            chk({name, "_zero_hold"}, 64'(sib.data_hold_o), 64'd1);
            return;
          end
          case (hmode)
            1:       hold = !held;
            2:       hold = (($urandom % 2) == 1);
            default: hold = 1'b0;
          endcase
          held       = hold;
          sib.hold_i = hold;
          if (!hold) void'(exq.pop_front());
        end
      end
      if (done_o) begin
        done_seen = 1'b1;
        chk({name, "_done_hold"}, 64'(sib.data_hold_o), 64'd1);
        chk({name, "_done_busy"}, 64'(busy_o), 64'd0);
      end else if (!sib.data_hold_o && widx < words.size()) begin
        offer = 1'b1;
        if (rgap && ($urandom % 4) == 0) offer = 1'b0;
        if (gap_word > 0 && widx == gap_word && gap_left > 0) begin
          chk({name, "_gap_valid"}, 64'(sib.valid_o), 64'd0);
          gap_left--;
          offer = 1'b0;
        end
        if (offer) begin
          sib.data_valid_i = 1'b1;
          sib.data_i       = words[widx];
          if (widx == 1) w1_cyc = cyc;
          if (gap_word > 0 && widx == gap_word) resume = 1'b1;
          widx++;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    chk({name, "_finished"}, 64'(done_seen), 64'd1);
    chk({name, "_all_xfers"}, 64'(exq.size()), 64'd0);
    chk({name, "_words_used"}, 64'(widx), 64'(words.size()));
    if (lat > 0) chk({name, "_first_latency"}, 64'(fv_cyc - w1_cyc), 64'(lat));
    if (gap_word > 0) chk({name, "_gap_len"}, 64'(gap_left), 64'd0);

    // back in IDLE: a presented word must not be taken
    sib.data_valid_i = 1'b1;
    sib.data_i       = {$urandom, $urandom};
    sib.hold_i       = 1'b0;
    chk({name, "_idle_hold"}, 64'(sib.data_hold_o), 64'd1);
    chk({name, "_single_done"}, 64'(done_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_idle_valid"}, 64'(sib.valid_o), 64'd0);
    chk({name, "_idle_hold2"}, 64'(sib.data_hold_o), 64'd1);
    sib.data_valid_i = 1'b0;
  endtask

  initial begin
    sib.data_valid_i = 1'b0;
    sib.data_i       = '0;
    sib.hold_i       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(sib.valid_o), 64'd0);
    chk("rst_hold", 64'(sib.data_hold_o), 64'd1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_indexi", 64'(sib.indexi_o), 64'd0);
    chk("rst_indexj", 64'(sib.indexj_o), 64'd0);
    chk("rst_sign", 64'(sib.sign_o), 64'd0);

    // all-zero bytes, sign pattern 1,0,1
    pre = {};
    for (int k = 0; k < 64; k++) pre.push_back(8'h00);
    run_case("zeros", 64'h0000_0000_0000_0005, 0, 1'b0, 1, 0, 0, 1'b0);

    // two rejects then j == i at i = 196, shuffler holds each request once
    pre = {};
    pre.push_back(8'hFF);
    pre.push_back(8'hC5);
    pre.push_back(8'hC4);
    run_case("reject", {$urandom, $urandom}, 1, 1'b0, 3, 0, 0, 1'b0);

    // random bytes, random hold, random stream gaps, ignored start_i
    pre = {};
    run_case("random", {$urandom, $urandom}, 2, 1'b1, 0, 0, 0, 1'b1);

    // empty buffer with stream stalled for 5 cycles
    pre = {};
    for (int k = 0; k < 9; k++) pre.push_back(8'h00);
    run_case("gap", {$urandom, $urandom}, 0, 1'b0, 0, 2, 0, 1'b0);

    // zeroize at i = 210 mid-handshake, then a fresh run
    pre = {};
    run_case("zeroize", {$urandom, $urandom}, 0, 1'b0, 0, 0, 210, 1'b0);
    pre = {};
    run_case("restart", {$urandom, $urandom}, 1, 1'b0, 0, 0, 0, 1'b0);

    // final transfer from byte 2 of a word, rest of it discarded
    pre = {};
    for (int k = 0; k < 7; k++) pre.push_back(8'hFF);
    for (int k = 0; k < 60; k++) pre.push_back(8'h00);
    run_case("tail", {$urandom, $urandom}, 0, 1'b0, 8, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
